// File: rtl/lfsr_sizing_chain.sv
// Capacity benchmark: a serial chain of XNOR-feedback shift-register cells.
// Every flop shares one clock and one asynchronous active-low clear.

module lfsr_xnor (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a ^ b);
endmodule

module lfsr_fd2 (
  input  logic d,
  input  logic clk,
  input  logic reset,
  output logic q,
  output logic qn
);
  logic state_q;
  logic state_d;

  always_comb begin
    state_d = d;
  end

  // The clear wins over a coincident clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= 1'b0;
    else        state_q <= state_d;
  end

  assign q  = state_q;
  assign qn = ~state_q;
endmodule

module lfsr_cell #(
  parameter int CELL_LEN = 10,
  parameter int TAP      = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  logic [CELL_LEN:1] s_q;
  logic [CELL_LEN:1] s_d;
  logic [CELL_LEN:1] qn_unused;
  logic              fb;

  lfsr_xnor u_xnor (
    .a(din),
    .b(s_q[TAP]),
    .y(fb)
  );

  always_comb begin
    s_d[1] = fb;
    for (int k = 2; k <= CELL_LEN; k++) s_d[k] = s_q[k-1];
  end

  for (genvar k = 1; k <= CELL_LEN; k++) begin : g_stage
    lfsr_fd2 u_fd2 (
      .d    (s_d[k]),
      .clk  (clk),
      .reset(reset),
      .q    (s_q[k]),
      .qn   (qn_unused[k])
    );
  end

  assign dout = s_q[CELL_LEN];
endmodule

module lfsr_group #(
  parameter int NUM      = 1000,
  parameter int CELL_LEN = 10,
  parameter int TAP      = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  logic [NUM:0] link;

  assign link[0] = din;

  for (genvar c = 0; c < NUM; c++) begin : g_cell
    lfsr_cell #(.CELL_LEN(CELL_LEN), .TAP(TAP)) u_cell (
      .clk  (clk),
      .reset(reset),
      .din  (link[c]),
      .dout (link[c+1])
    );
  end

  assign dout = link[NUM];
endmodule

module lfsr_sizing_chain #(
  parameter int NUM_CELLS = 8000,
  parameter int CELL_LEN  = 10,
  parameter int TAP       = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  // Whole multiples of a thousand cells are split into thousand-cell groups.
  localparam int GROUP_SIZE  = 1000;
  localparam bit GROUPED     = (NUM_CELLS >= GROUP_SIZE) && (NUM_CELLS % GROUP_SIZE == 0);
  localparam int NUM_GROUPS  = GROUPED ? NUM_CELLS / GROUP_SIZE : 1;
  localparam int GROUP_CELLS = GROUPED ? GROUP_SIZE : NUM_CELLS;

  logic [NUM_GROUPS:0] group_link;

  assign group_link[0] = d;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
    lfsr_group #(.NUM(GROUP_CELLS), .CELL_LEN(CELL_LEN), .TAP(TAP)) u_group (
      .clk  (clk),
      .reset(reset),
      .din  (group_link[g]),
      .dout (group_link[g+1])
    );
  end

  assign q = group_link[NUM_GROUPS];
endmodule

// File: tb/tb_lfsr_sizing_chain.sv
// Scoreboarded bench: single-cell, three-cell, default-size and ring chains
// against a recurrence model of each cell's first stage.

module tb_lfsr_sizing_chain;
  logic clk = 1'b0;
  logic reset;
  logic d;
  logic ring_d;
  logic q1, q3, q_big, q_ring;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  bit running;

  typedef struct {
    bit e1;
    bit e3;
    bit e_big;
    bit e_ring;
    int edge_no;
  } exp_t;

  exp_t sb[$];

  bit hist [0:3][0:7999][0:15];
  int t_model [0:3];
  int n_cells [0:3] = '{1, 3, 8000, 1};
  bit ring_prev;

  always #5 clk = ~clk;

  assign ring_d = q_ring;

  lfsr_sizing_chain #(.NUM_CELLS(1)) u_dut1 (
    .clk(clk), .reset(reset), .d(d), .q(q1));
  lfsr_sizing_chain #(.NUM_CELLS(3)) u_dut3 (
    .clk(clk), .reset(reset), .d(d), .q(q3));
  lfsr_sizing_chain u_dut_big (
    .clk(clk), .reset(reset), .d(d), .q(q_big));
  lfsr_sizing_chain #(.NUM_CELLS(1)) u_dut_ring (
    .clk(clk), .reset(reset), .d(ring_d), .q(q_ring));

  // Recurrence per cell: s1(t) = ~(din(t) ^ s1(t-7)), q(t) = s1(t-9),
  // where din of a downstream cell is the upstream q one edge earlier.
  function automatic bit model_step(input int m, input bit din_first);
    int t;
    bit din;
    t_model[m]++;
    t = t_model[m];
    for (int c = 0; c < n_cells[m]; c++) begin
      din = (c == 0) ? din_first : hist[m][c-1][(t-10) & 15];
      hist[m][c][t & 15] = ~(din ^ hist[m][c][(t-7) & 15]);
    end
    return hist[m][n_cells[m]-1][(t-9) & 15];
  endfunction

  function automatic void model_clear();
    for (int m = 0; m < 4; m++) begin
      t_model[m] = 0;
      for (int c = 0; c < n_cells[m]; c++)
        for (int s = 0; s < 16; s++) hist[m][c][s] = 1'b0;
    end
    ring_prev = 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s edge %0d: got %b, expected %b", name, edge_no, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rst_val, input bit d_val);
    exp_t e;
    reset = rst_val;
    d     = d_val;
    edge_no++;
    e.edge_no = edge_no;
    if (!rst_val) begin
      model_clear();
      e.e1 = 1'b0; e.e3 = 1'b0; e.e_big = 1'b0; e.e_ring = 1'b0;
    end else begin
      e.e1     = model_step(0, d_val);
      e.e3     = model_step(1, d_val);
      e.e_big  = model_step(2, d_val);
      e.e_ring = model_step(3, ring_prev);
      ring_prev = e.e_ring;
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every rising edge presents a new serial output bit.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (running) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard_empty edge %0d: got 0 entries, expected 1", edge_no);
        end else begin
          e = sb.pop_front();
          checkOutput("q_cells1", q1, e.e1);
          checkOutput("q_cells3", q3, e.e3);
          checkOutput("q_cells8000", q_big, e.e_big);
          checkOutput("q_ring", q_ring, e.e_ring);
        end
      end
    end
  end

  initial begin
    running = 1'b1;
    reset   = 1'b1;
    d       = 1'b0;
    #2;
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("reset_q1", q1, 1'b0);
    checkOutput("reset_q_big", q_big, 1'b0);

    repeat (30) applyStimulus(1'b1, 1'b0);

    repeat (2) applyStimulus(1'b0, 1'b0);
    repeat (12) applyStimulus(1'b1, 1'b0);
    // Asynchronous clear between edges 12 and 13, no clock edge involved.
    reset = 1'b0;
    #1;
    checkOutput("async_q1", q1, 1'b0);
    checkOutput("async_q3", q3, 1'b0);
    checkOutput("async_q_big", q_big, 1'b0);
    checkOutput("async_q_ring", q_ring, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0);
    repeat (20) applyStimulus(1'b1, 1'b0);

    repeat (20) applyStimulus(1'b0, 1'b0);
    repeat (50) applyStimulus(1'b1, 1'b1);

    repeat (2) applyStimulus(1'b0, 1'b0);
    repeat (300) applyStimulus(1'b1, 1'($urandom_range(0, 1)));

    running = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
